// File: rtl/icache_line_fill.sv
// Line-fill adapter: turns one wide cache-line read into NUM_BLOCKS sequential narrow word reads.
// Latency NUM_BLOCKS+1 cycles with zero-wait memory; an issued narrow beat is always drained on abort.
module icache_line_fill #(
    parameter int BLOCK_SIZE = 4,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 line_req_valid,
    output logic                                 line_req_ready,
    input  logic [31:0]                          line_req_addr,
    output logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]   line_req_rdata,
    output logic                                 mem_valid,
    input  logic                                 mem_ready,
    output logic [31:0]                          mem_addr,
    input  logic [8*BLOCK_SIZE-1:0]              mem_rdata,
    output logic                                 mem_instr,
    output logic [BLOCK_SIZE-1:0]                mem_wstrb,
    output logic [31:0]                          fill_count
);

    localparam int WORD_W = 8 * BLOCK_SIZE;
    localparam int OFFS   = $clog2(NUM_BLOCKS) + $clog2(BLOCK_SIZE);
    localparam int BEAT_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BLOCKS - 1);
    localparam logic [31:0]       LINE_MASK = 32'((64'd1 << OFFS) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        DRAIN
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;

    assign mem_instr = 1'b1;
    assign mem_wstrb = '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            beat           <= '0;
            line_req_ready <= 1'b0;
            line_req_rdata <= '0;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            fill_count     <= '0;
        end else begin
            line_req_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_req_valid) begin
                        mem_addr  <= line_req_addr & ~LINE_MASK;
                        mem_valid <= 1'b1;
                        beat      <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (!line_req_valid) begin
                        // Abort: a beat accepted this cycle is simply dropped; a pending one must finish.
                        if (mem_ready) begin
                            mem_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_ready) begin
                        line_req_rdata[beat*WORD_W +: WORD_W] <= mem_rdata;
                        if (beat == LAST_BEAT) begin
                            mem_valid      <= 1'b0;
                            line_req_ready <= 1'b1;
                            fill_count     <= fill_count + 32'd1;
                            state          <= DONE;
                        end else begin
                            beat     <= beat + BEAT_W'(1);
                            mem_addr <= mem_addr + 32'(BLOCK_SIZE);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// Randomized scoreboard bench for icache_line_fill: memory returns word = address,
// expected lines come from an address-arithmetic model and are checked by an independent monitor.
module tb_icache_line_fill;

    localparam int BS   = 4;
    localparam int NB   = 4;
    localparam int W    = 8 * BS;
    localparam int LW   = W * NB;
    localparam int OFFS = $clog2(NB) + $clog2(BS);

    logic          clk;
    logic          resetn;
    logic          line_req_valid;
    logic          line_req_ready;
    logic [31:0]   line_req_addr;
    logic [LW-1:0] line_req_rdata;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [W-1:0]  mem_rdata;
    logic          mem_instr;
    logic [BS-1:0] mem_wstrb;
    logic [31:0]   fill_count;

    icache_line_fill #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .line_req_valid (line_req_valid),
        .line_req_ready (line_req_ready),
        .line_req_addr  (line_req_addr),
        .line_req_rdata (line_req_rdata),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_instr      (mem_instr),
        .mem_wstrb      (mem_wstrb),
        .fill_count     (fill_count)
    );

    typedef struct {
        logic [LW-1:0] line;
        logic [31:0]   cnt;
        int            start;
        int            lat;
    } sb_t;

    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wait_mode = 0;
    logic [31:0] model_count = 0;
    logic        rst_at_edge = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
        rst_at_edge = resetn;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] exp_line(input logic [31:0] a);
        logic [LW-1:0] r;
        logic [31:0]   b;
        b = {a[31:OFFS], {OFFS{1'b0}}};
        r = '0;
        for (int k = 0; k < NB; k++) r[k*W +: W] = b + 32'(k * BS);
        return r;
    endfunction

    // Memory model: word = address, wait states per beat from wait_mode (-1 = random 0..3).
    initial begin
        int          wl;
        int          burst_n;
        logic        prev_vld, prev_rdy;
        logic [31:0] prev_addr, last_beat;
        mem_ready = 1'b0;
        mem_rdata = '0;
        wl = 0; burst_n = 0;
        prev_vld = 1'b0; prev_rdy = 1'b0; prev_addr = '0; last_beat = '0;
        forever begin
            @(negedge clk);
            if (prev_vld === 1'b1 && rst_at_edge === 1'b1) begin
                if (!prev_rdy) begin
                    chk("mem_hold_valid", LW'(mem_valid), LW'(1));
                    chk("mem_hold_addr", LW'(mem_addr), LW'(prev_addr));
                end else begin
                    if (burst_n == 0) chk("beat_align", LW'(prev_addr & 32'(2**OFFS - 1)), '0);
                    else chk("beat_step", LW'(prev_addr), LW'(last_beat + 32'(BS)));
                    last_beat = prev_addr;
                    burst_n++;
                end
            end
            if (prev_vld === 1'b1 && prev_rdy) wl = (wait_mode < 0) ? $urandom_range(0, 3) : wait_mode;
            if (mem_valid !== 1'b1) begin
                burst_n   = 0;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wl = (wait_mode < 0) ? $urandom_range(0, 3) : wait_mode;
            end else if (wl == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wl--;
            end
            prev_vld  = mem_valid;
            prev_rdy  = mem_ready;
            prev_addr = mem_addr;
        end
    end

    // Scoreboard monitor: every ready pulse must match the oldest outstanding expectation.
    initial forever begin
        sb_t e;
        @(negedge clk);
        if (line_req_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready: got line_req_ready=1 required no pulse");
            end else begin
                e = sb_q.pop_front();
                chk("line_data", line_req_rdata, e.line);
                chk("fill_count", LW'(fill_count), LW'(e.cnt));
                if (e.lat >= 0) chk("latency", LW'(cyc - e.start), LW'(e.lat));
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input int lat);
        sb_t e;
        model_count    = model_count + 32'd1;
        e.line         = exp_line(a);
        e.cnt          = model_count;
        e.start        = cyc;
        e.lat          = lat;
        sb_q.push_back(e);
        line_req_addr  = a;
        line_req_valid = 1'b1;
    endtask

    task automatic cancel_req();
        line_req_valid = 1'b0;
        if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        model_count = model_count - 32'd1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mem_valid !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", LW'(mem_valid), '0);
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (line_req_ready !== 1'b1 && k < 200);
        chk("fill_done", LW'(line_req_ready), LW'(1));
        if (line_req_ready !== 1'b1) begin
            cancel_req();
            wait_idle();
        end else begin
            line_req_valid = 1'b0;
        end
    endtask

    initial begin
        resetn = 1'b0;
        line_req_valid = 1'b0;
        line_req_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", LW'(line_req_ready), '0);
        chk("rst_mem_valid", LW'(mem_valid), '0);
        chk("rst_mem_addr", LW'(mem_addr), '0);
        chk("rst_rdata", line_req_rdata, '0);
        chk("rst_fill_count", LW'(fill_count), '0);
        chk("mem_instr", LW'(mem_instr), LW'(1));
        chk("mem_wstrb", LW'(mem_wstrb), '0);
        resetn = 1'b1;

        // Zero-wait fill with beat address sequence.
        wait_mode = 0;
        @(negedge clk);
        start_req(32'h0000_1234, NB + 1);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            chk("zw_mem_valid", LW'(mem_valid), LW'(1));
            chk("zw_mem_addr", LW'(mem_addr), LW'(32'h1230 + 32'(k * BS)));
        end
        wait_done();

        // Two wait states per beat.
        wait_mode = 2;
        @(negedge clk);
        start_req(32'h0000_4560, 1 + NB * 3);
        wait_done();

        // Abort after beat 1 while beat 2 is still waiting: must drain.
        @(negedge clk);
        start_req(32'h0000_3000, -1);
        repeat (7) @(negedge clk);
        cancel_req();
        @(negedge clk);
        chk("drain_valid", LW'(mem_valid), LW'(1));
        chk("drain_addr", LW'(mem_addr), LW'(32'h3008));
        repeat (2) @(negedge clk);
        chk("drain_release", LW'(mem_valid), '0);
        chk("abort_count", LW'(fill_count), LW'(model_count));
        start_req(32'h0000_2000, 1 + NB * 3);
        wait_done();

        // Abort coincident with mem_ready: straight back to idle.
        wait_mode = 0;
        @(negedge clk);
        start_req(32'h0000_5000, -1);
        repeat (2) @(negedge clk);
        cancel_req();
        @(negedge clk);
        chk("coinc_valid", LW'(mem_valid), '0);
        chk("coinc_count", LW'(fill_count), LW'(model_count));

        // Back-to-back fills following the cache handshake.
        @(negedge clk);
        start_req(32'h0000_0100, NB + 1);
        wait_done();
        @(negedge clk);
        start_req(32'h0000_0200, NB + 1);
        wait_done();
        @(negedge clk);
        chk("b2b_count", LW'(fill_count), LW'(model_count));

        // Reset in the middle of a fill.
        start_req(32'h0000_7000, -1);
        repeat (2) @(negedge clk);
        cancel_req();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mrst_ready", LW'(line_req_ready), '0);
        chk("mrst_mem_valid", LW'(mem_valid), '0);
        chk("mrst_mem_addr", LW'(mem_addr), '0);
        chk("mrst_rdata", line_req_rdata, '0);
        chk("mrst_fill_count", LW'(fill_count), '0);
        model_count = '0;
        sb_q.delete();
        @(negedge clk);
        start_req(32'h0000_8000, NB + 1);
        wait_done();

        // Top of the address space.
        wait_mode = 1;
        @(negedge clk);
        start_req(32'hFFFF_FFFC, 1 + NB * 2);
        wait_done();

        // Random addresses, wait states and aborts.
        wait_mode = -1;
        for (int i = 0; i < 40; i++) begin
            int k, ab;
            bit fin;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            @(negedge clk);
            start_req($urandom, -1);
            k = 0;
            fin = 1'b0;
            while (!fin) begin
                @(negedge clk);
                k++;
                if (line_req_ready === 1'b1) begin
                    line_req_valid = 1'b0;
                    fin = 1'b1;
                end else if (k == ab || k > 200) begin
                    if (k > 200) chk("rand_timeout", LW'(line_req_ready), LW'(1));
                    cancel_req();
                    wait_idle();
                    fin = 1'b1;
                end
            end
            chk("rand_count", LW'(fill_count), LW'(model_count));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", LW'(sb_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Memory-side line-fill adapter directly downstream of the wide-port direct-mapped instruction cache.
- Accepts one wide cache-line read request. Issues NUM_BLOCKS sequential narrow word reads on the native single-word memory bus, then returns the assembled line with a one-cycle ready pulse.
- Supports abort: if the cache drops its request mid-fill, the outstanding narrow beat is drained and no line is returned.

Parameters:
- BLOCK_SIZE, 4, narrow word size in bytes; narrow bus width = 8*BLOCK_SIZE.
- NUM_BLOCKS, 4, words per cache line; line width = 8*BLOCK_SIZE*NUM_BLOCKS.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- line_req_valid  in  1  cache requests a line fill; held high until line_req_ready is seen or the request is aborted.
- line_req_ready  out  1  one-cycle pulse; line_req_rdata is valid in the same cycle.
- line_req_addr  in  32  line address from the cache; low offset bits are ignored.
- line_req_rdata  out  8*BLOCK_SIZE*NUM_BLOCKS  assembled line; word k sits at bits [k*8*BLOCK_SIZE +: 8*BLOCK_SIZE].
- mem_valid  out  1  narrow read request.
- mem_ready  in  1  narrow beat acknowledge; mem_rdata is valid in the same cycle.
- mem_addr  out  32  narrow word address.
- mem_rdata  in  8*BLOCK_SIZE  narrow read data.
- mem_instr  out  1  constant 1 (instruction fetch).
- mem_wstrb  out  BLOCK_SIZE  constant 0 (read only).
- fill_count  out  32  number of completed (non-aborted) line fills, debug.

Behaviour:
- Reset values: line_req_ready=0, mem_valid=0, mem_addr=0, line_req_rdata=0, fill_count=0, beat counter=0, state=IDLE. All outputs are registered.
- Constants: OFFS = log2(NUM_BLOCKS)+log2(BLOCK_SIZE). Beat counter width = log2(NUM_BLOCKS), minimum 1 bit.
- FSM states: IDLE, REQ, DONE, DRAIN.
- IDLE:
  - On line_req_valid=1, capture base = {line_req_addr[31:OFFS], OFFS zeros}.
  - Next cycle: mem_addr=base, mem_valid=1, beat=0, state REQ.
  - line_req_valid=0: stay in IDLE.
- REQ, line_req_valid=1 and mem_ready=1:
  - Write mem_rdata into line slot beat.
  - If beat==NUM_BLOCKS-1: mem_valid<=0, line_req_ready<=1, fill_count<=fill_count+1, go DONE.
  - Otherwise: beat<=beat+1, mem_addr<=mem_addr+BLOCK_SIZE, mem_valid stays 1 (back-to-back beats, no idle cycle).
- REQ, mem_ready=0: hold mem_valid and mem_addr stable.
- REQ, abort (line_req_valid=0):
  - If mem_ready=1 in the same cycle: discard the beat, mem_valid<=0, go IDLE.
  - Otherwise: go DRAIN with mem_valid held at 1 and mem_addr unchanged. A narrow transaction is never retracted.
- DRAIN: on mem_ready, mem_valid<=0, go IDLE. line_req_valid is ignored in this state; a new request is served only from IDLE.
- DONE:
  - line_req_ready=1 for exactly one cycle. line_req_rdata holds the full line and remains stable afterwards until the next fill writes it.
  - Next state is IDLE unconditionally.
  - The cache deasserts its request on the edge ending DONE, so no spurious refill occurs.
- Latency with zero-wait memory: request seen in cycle 0 -> beats in cycles 1..NUM_BLOCKS -> line_req_ready in cycle NUM_BLOCKS+1. Default is 5 cycles.
- Aborted fills never pulse line_req_ready and never increment fill_count.
- fill_count wraps modulo 2^32.
- Reset mid-fill: return to IDLE next cycle with mem_valid=0. Memory-side recovery is the memory model's responsibility.
- Address arithmetic: 32-bit. A fill at the top of the address space wraps within 32 bits, with no special handling.

Test Plan:
- Zero-wait fill: line_req_addr=0x0000_1234, memory returns word = address.
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles.
  - line_req_ready in cycle 5; line_req_rdata = {0x123C, 0x1238, 0x1234, 0x1230}; fill_count=1.
- Wait states: memory inserts 2 wait cycles per beat.
  - mem_addr is stable while waiting.
  - line_req_ready in cycle 13 with the correct line.
  - mem_valid is never deasserted between beats.
- Abort mid-fill: drop line_req_valid after beat 1 while beat 2 waits.
  - FSM enters DRAIN; mem_valid stays high until mem_ready, then goes low.
  - No line_req_ready; fill_count unchanged; a new request at 0x2000 fills correctly.
- Abort coincident with mem_ready: FSM goes straight to IDLE and mem_valid=0 next cycle.
- Back-to-back fills emulating the cache handshake, 0x100 then 0x200:
  - Exactly one line_req_ready per fill, each with the correct data; fill_count=2.
- Reset mid-REQ: assert resetn=0 for one cycle.
  - All outputs return to reset values; the subsequent fill completes normally.
